// File: rtl/fetch_unit.sv
// fetch_unit
// ----------
// Front end of the fetch path. Holds the architectural PC, issues word fetches
// to instruction memory over a req/ack handshake (one request outstanding),
// and buffers returned instructions with their PCs in a small FIFO for decode.
// Branch redirects from execute flush buffered work and steer fetch to a new
// target. A request already in flight when a redirect arrives is killed: it
// stays on the bus until acked, and its data is then thrown away.
//
// Handshakes:
//   Imem*  : a transfer happens on a rising edge where ImemReq & ImemAck.
//            ImemReq/ImemAddr stay stable from assertion until the transfer.
//            ImemAck without ImemReq is ignored.
//   Instr* : the head entry is consumed on a rising edge where
//            InstrValid & InstrReady and Redirect is low.
//
// Ports:
//   CLK         clock, rising edge
//   Reset_L     asynchronous active-low reset
//   Redirect    taken-branch strobe from execute (one cycle per event)
//   RedirectPC  branch target, bits [1:0] treated as 0
//   ImemReq     fetch request (registered)
//   ImemAddr    fetch address (registered, word aligned)
//   ImemAck     memory accepts the request and returns data this cycle
//   ImemData    instruction word, valid with ImemAck
//   InstrValid  FIFO head valid
//   InstrReady  decode accepts the head
//   Instr       head instruction
//   InstrPC     PC of the head instruction
//   Count       FIFO occupancy
//   fsm_state   fetch FSM state, for debug/observation (0 IDLE, 1 WAIT, 2 KILL)

module fetch_unit #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int          DEPTH    = 2
) (
    input  logic                     CLK,
    input  logic                     Reset_L,
    input  logic                     Redirect,
    input  logic [63:0]              RedirectPC,
    output logic                     ImemReq,
    output logic [63:0]              ImemAddr,
    input  logic                     ImemAck,
    input  logic [31:0]              ImemData,
    output logic                     InstrValid,
    input  logic                     InstrReady,
    output logic [31:0]              Instr,
    output logic [63:0]              InstrPC,
    output logic [$clog2(DEPTH):0]   Count,
    output logic [1:0]               fsm_state
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    localparam logic [1:0] ST_IDLE = 2'd0;  // no request outstanding
    localparam logic [1:0] ST_WAIT = 2'd1;  // right-path request outstanding
    localparam logic [1:0] ST_KILL = 2'd2;  // wrong-path request outstanding

    logic [1:0]    state, state_n;
    logic [63:0]   pc, pc_n;
    logic          req_n;
    logic [63:0]   addr_n;
    logic [CW-1:0] count_q, count_n;
    logic [AW-1:0] rd_ptr, wr_ptr, rd_next;
    logic [31:0]   head_instr;
    logic [63:0]   head_pc;

    logic [31:0]   fifo_instr [DEPTH];
    logic [63:0]   fifo_pc    [DEPTH];

    logic [63:0]   redirect_pc;
    logic [63:0]   pc_inc;
    logic          transfer;
    logic          push;
    logic          pop;
    logic          room;

    assign redirect_pc = RedirectPC & ~64'h3;
    assign pc_inc      = pc + 64'd4;
    assign transfer    = ImemReq & ImemAck;

    // Only a right-path transfer delivers data; a redirect drops anything
    // arriving at the same edge.
    assign push = transfer && (state == ST_WAIT) && !Redirect;
    assign pop  = InstrValid && InstrReady && !Redirect;

    // Occupancy after this edge. The room test for issuing a new request looks
    // at this value so that a same-cycle pop frees space immediately.
    assign count_n = Redirect ? '0 : (count_q + CW'(push) - CW'(pop));
    assign room    = count_n < DEPTH_C;
    assign rd_next = rd_ptr + AW'(pop);

    always_comb begin
        state_n = state;
        pc_n    = pc;
        req_n   = ImemReq;
        addr_n  = ImemAddr;
        if (Redirect) begin
            pc_n = redirect_pc;
            case (state)
                ST_WAIT, ST_KILL: begin
                    if (transfer) begin
                        req_n   = 1'b1;
                        addr_n  = redirect_pc;
                        state_n = ST_WAIT;
                    end else begin
                        // Request stays on the bus; its data will be dropped.
                        state_n = ST_KILL;
                    end
                end
                default: begin
                    req_n   = 1'b1;
                    addr_n  = redirect_pc;
                    state_n = ST_WAIT;
                end
            endcase
        end else begin
            case (state)
                ST_IDLE: begin
                    if (room) begin
                        req_n   = 1'b1;
                        addr_n  = pc;
                        state_n = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (transfer) begin
                        pc_n = pc_inc;
                        if (room) begin
                            addr_n = pc_inc;
                        end else begin
                            req_n   = 1'b0;
                            state_n = ST_IDLE;
                        end
                    end
                end
                ST_KILL: begin
                    if (transfer) begin
                        if (room) begin
                            addr_n  = pc;
                            state_n = ST_WAIT;
                        end else begin
                            req_n   = 1'b0;
                            state_n = ST_IDLE;
                        end
                    end
                end
                default: begin
                    req_n   = 1'b0;
                    state_n = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            state    <= ST_IDLE;
            pc       <= RESET_PC;
            ImemReq  <= 1'b0;
            ImemAddr <= RESET_PC;
        end else begin
            state    <= state_n;
            pc       <= pc_n;
            ImemReq  <= req_n;
            ImemAddr <= addr_n;
        end
    end

    // FIFO storage needs no reset; validity is carried by the occupancy count.
    always_ff @(posedge CLK) begin
        if (push) begin
            fifo_instr[wr_ptr] <= ImemData;
            fifo_pc[wr_ptr]    <= pc;
        end
    end

    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count_q    <= '0;
            head_instr <= '0;
            head_pc    <= '0;
        end else begin
            count_q <= count_n;
            if (Redirect) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                rd_ptr <= rd_next;
                if (push) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                // The head registers hold their last value while empty. When
                // the new head slot is the one being written this edge, the
                // incoming word is taken directly.
                if (count_n != '0) begin
                    if (push && (rd_next == wr_ptr)) begin
                        head_instr <= ImemData;
                        head_pc    <= pc;
                    end else begin
                        head_instr <= fifo_instr[rd_next];
                        head_pc    <= fifo_pc[rd_next];
                    end
                end
            end
        end
    end

    assign InstrValid = (count_q != '0);
    assign Instr      = head_instr;
    assign InstrPC    = head_pc;
    assign Count      = count_q;
    assign fsm_state  = state;

endmodule
